// File: rtl/axi_lite_wr_front.sv
// axi_lite_wr_front: AXI4-Lite write front end; pairs AW/W beats into a one-cycle register write strobe.
// Rev 1.0
`default_nettype none

module axi_lite_wr_front #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  output logic                              slv_reg_wren,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   slv_wstrb
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                              aw_full;
  logic                              w_full;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     w_data_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   w_strb_q;
  logic                              aw_hs;
  logic                              w_hs;
  logic                              commit;
  logic                              in_range;
  logic [31:0]                       reg_index;
  logic                              unused_prot;

  assign unused_prot = ^S_AXI_AWPROT;

  // READY is gated by reset so it reads 0 during reset regardless of flag timing.
  assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_full;
  assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_full;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID  & S_AXI_WREADY;
  assign commit    = aw_full & w_full & (~S_AXI_BVALID | S_AXI_BREADY);
  assign reg_index = 32'(aw_addr_q[C_S_AXI_ADDR_WIDTH-1:2]);
  assign in_range  = reg_index < 32'(C_NUM_REGS);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
    end else if (aw_hs) begin
      aw_full   <= 1'b1;
      aw_addr_q <= S_AXI_AWADDR;
    end else if (commit) begin
      aw_full   <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_full   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (w_hs) begin
      w_full   <= 1'b1;
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end else if (commit) begin
      w_full   <= 1'b0;
    end
  end

  // A commit on the same edge as BREADY replaces the response without a bubble.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      slv_reg_wren <= 1'b0;
      axi_awaddr   <= '0;
      slv_wdata    <= '0;
      slv_wstrb    <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      slv_reg_wren <= in_range;
      axi_awaddr   <= aw_addr_q;
      slv_wdata    <= w_data_q;
      slv_wstrb    <= w_strb_q;
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      slv_reg_wren <= 1'b0;
      if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
